// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter: ALU/load merge, register-file write port, pending-load scoreboard
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     pend_set,
    input  logic [4:0]               pend_rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     rf_wen,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]   lsu_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            sel_from_lsu;
    logic            rf_from_lsu;
    logic [31:0]     sb;
    logic [31:0]     sb_next;

    // Ready is based on start-of-cycle occupancy, so a same-cycle pop never admits a push when full
    assign lsu_ready = (count < CW'(DEPTH));
    assign push      = lsu_valid && lsu_ready;
    // ALU results always win; the FIFO only drains in cycles without ALU traffic
    assign pop       = !alu_valid && (count != '0);
    assign lsu_count = count;

    assign rs1_busy  = (rs1 != 5'd0) && sb[rs1];
    assign rs2_busy  = (rs2 != 5'd0) && sb[rs2];

    // Fixed-priority selection between the ALU result and the FIFO head
    always_comb begin
        sel_valid    = 1'b0;
        sel_rd       = 5'd0;
        sel_data     = '0;
        sel_from_lsu = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (pop) begin
            sel_valid    = 1'b1;
            sel_rd       = fifo_rd[rd_ptr];
            sel_data     = fifo_data[rd_ptr];
            sel_from_lsu = 1'b1;
        end
    end

    // Load-result storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered register-file write port; writes to x0 are consumed but never asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen      <= 1'b0;
            rf_rd       <= 5'd0;
            rf_wdata    <= '0;
            rf_from_lsu <= 1'b0;
        end else begin
            rf_wen <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid && (sel_rd != 5'd0)) begin
                rf_rd       <= sel_rd;
                rf_wdata    <= sel_data;
                rf_from_lsu <= sel_from_lsu;
            end
        end
    end

    // Next scoreboard: a retiring load clears its bit, a new issue sets it, set applied last so it wins
    always_comb begin
        sb_next = sb;
        if (rf_wen && rf_from_lsu) sb_next[rf_rd] = 1'b0;
        if (pend_set && (pend_rd != 5'd0)) sb_next[pend_rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb <= '0;
        else        sb <= sb_next;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table-driven self-checking bench for wb_arbiter
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic             clk;
    logic             rst_n;
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [4:0]       lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    logic             pend_set;
    logic [4:0]       pend_rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rf_wen;
    logic [4:0]       rf_rd;
    logic [XLEN-1:0]  rf_wdata;
    logic [$clog2(DEPTH):0] lsu_count;

    int checks;
    int errors;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .pend_set  (pend_set),
        .pend_rd   (pend_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rf_wen    (rf_wen),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .lsu_count (lsu_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        ps;
        logic [4:0]  prd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ready;
        logic        e_b1;
        logic        e_b2;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_wdata;
        int          e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
        input logic ps, input logic [4:0] prd, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_ready, input logic e_b1, input logic e_b2,
        input logic e_wen, input logic [4:0] e_rd, input logic [31:0] e_wdata, input int e_cnt);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.ps = ps; v.prd = prd; v.r1 = r1; v.r2 = r2;
        v.e_ready = e_ready; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_wen = e_wen; v.e_rd = e_rd; v.e_wdata = e_wdata; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
        pend_set = 1'b0; pend_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle, then registered outputs after the edge
    task automatic run_vec(input vec_t v, input int idx);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
        pend_set = v.ps; pend_rd = v.prd; rs1 = v.r1; rs2 = v.r2;
        #2;
        check("lsu_ready", idx, 32'(lsu_ready), 32'(v.e_ready));
        check("rs1_busy",  idx, 32'(rs1_busy),  32'(v.e_b1));
        check("rs2_busy",  idx, 32'(rs2_busy),  32'(v.e_b2));
        @(posedge clk);
        #1;
        check("rf_wen",    idx, 32'(rf_wen),    32'(v.e_wen));
        check("lsu_count", idx, 32'(lsu_count), 32'(v.e_cnt));
        if (v.e_wen) begin
            check("rf_rd",    idx, 32'(rf_rd), 32'(v.e_rd));
            check("rf_wdata", idx, rf_wdata,   v.e_wdata);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_idle();

        //        av ard  adata          lv lrd ldata         ps prd r1 r2  rdy b1 b2  wen rd  wdata          cnt
        // ALU path, including a write to x0
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        vq.push_back(mk(1, 7,  32'hDEADBEEF, 0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 7,  32'hDEADBEEF, 0));
        vq.push_back(mk(1, 0,  32'h55,       0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        // Load of x9 with scoreboard: busy through N+2, clear in N+3
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      1, 9,  9, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        vq.push_back(mk(0, 0,  32'h0,        1, 9,  32'h1234,   0, 0,  9, 0,  1, 1, 0,  0, 0,  32'h0,        1));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  9, 0,  1, 1, 0,  1, 9,  32'h1234,     0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  9, 9,  1, 1, 1,  0, 0,  32'h0,        0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  9, 9,  1, 0, 0,  0, 0,  32'h0,        0));
        // Same-edge set and clear on x9: set wins
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      1, 9,  9, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        vq.push_back(mk(0, 0,  32'h0,        1, 9,  32'hAAAA,   0, 0,  9, 0,  1, 1, 0,  0, 0,  32'h0,        1));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  9, 0,  1, 1, 0,  1, 9,  32'hAAAA,     0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      1, 9,  9, 0,  1, 1, 0,  0, 0,  32'h0,        0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  9, 0,  1, 1, 0,  0, 0,  32'h0,        0));
        // x0 is never marked busy
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      1, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 9,  1, 0, 1,  0, 0,  32'h0,        0));
        // ALU priority for 6 cycles while 5 loads are offered; FIFO fills, then drains in order
        vq.push_back(mk(1, 20, 32'd100,      1, 1,  32'h11,     0, 0,  0, 0,  1, 0, 0,  1, 20, 32'd100,      1));
        vq.push_back(mk(1, 21, 32'd101,      1, 2,  32'h22,     0, 0,  0, 0,  1, 0, 0,  1, 21, 32'd101,      2));
        vq.push_back(mk(1, 22, 32'd102,      1, 3,  32'h33,     0, 0,  0, 0,  1, 0, 0,  1, 22, 32'd102,      3));
        vq.push_back(mk(1, 23, 32'd103,      1, 4,  32'h44,     0, 0,  0, 0,  1, 0, 0,  1, 23, 32'd103,      4));
        vq.push_back(mk(1, 24, 32'd104,      1, 5,  32'h55,     0, 0,  0, 0,  0, 0, 0,  1, 24, 32'd104,      4));
        vq.push_back(mk(1, 25, 32'd105,      1, 5,  32'h55,     0, 0,  0, 0,  0, 0, 0,  1, 25, 32'd105,      4));
        vq.push_back(mk(0, 0,  32'h0,        1, 5,  32'h55,     0, 0,  0, 0,  0, 0, 0,  1, 1,  32'h11,       3));
        vq.push_back(mk(0, 0,  32'h0,        1, 5,  32'h55,     0, 0,  0, 0,  1, 0, 0,  1, 2,  32'h22,       3));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 3,  32'h33,       2));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 4,  32'h44,       1));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 5,  32'h55,       0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        // Push and pop together at count 2
        vq.push_back(mk(1, 0,  32'h0,        1, 10, 32'hA0,     0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        1));
        vq.push_back(mk(1, 0,  32'h0,        1, 11, 32'hA1,     0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        2));
        vq.push_back(mk(0, 0,  32'h0,        1, 12, 32'hA2,     0, 0,  0, 0,  1, 0, 0,  1, 10, 32'hA0,       2));
        vq.push_back(mk(0, 0,  32'h0,        1, 13, 32'hA3,     0, 0,  0, 0,  1, 0, 0,  1, 11, 32'hA1,       2));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 12, 32'hA2,       1));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  1, 13, 32'hA3,       0));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));
        // Load to x0 is consumed without a write
        vq.push_back(mk(0, 0,  32'h0,        1, 0,  32'h77,     0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        1));
        vq.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,      0, 0,  0, 0,  1, 0, 0,  0, 0,  32'h0,        0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset rf_wen",    -1, 32'(rf_wen),    32'd0);
        check("reset rf_rd",     -1, 32'(rf_rd),     32'd0);
        check("reset rf_wdata",  -1, rf_wdata,       32'd0);
        check("reset lsu_count", -1, 32'(lsu_count), 32'd0);
        check("reset lsu_ready", -1, 32'(lsu_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        // Mid-stream reset: queue 3 loads behind ALU traffic with x5 pending
        run_vec(mk(1, 3, 32'h1, 1, 1, 32'hB1, 1, 5, 5, 0, 1, 0, 0, 1, 3, 32'h1, 1), 100);
        run_vec(mk(1, 3, 32'h2, 1, 2, 32'hB2, 0, 0, 5, 0, 1, 1, 0, 1, 3, 32'h2, 2), 101);
        run_vec(mk(1, 3, 32'h3, 1, 3, 32'hB3, 0, 0, 5, 0, 1, 1, 0, 1, 3, 32'h3, 3), 102);
        drive_idle();
        rs1 = 5'd5;
        #2;
        check("pre-reset rs1_busy",  200, 32'(rs1_busy),  32'd1);
        check("pre-reset lsu_count", 200, 32'(lsu_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async rf_wen",    201, 32'(rf_wen),    32'd0);
        check("async lsu_count", 201, 32'(lsu_count), 32'd0);
        check("async lsu_ready", 201, 32'(lsu_ready), 32'd1);
        check("async rs1_busy",  201, 32'(rs1_busy),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // After release nothing queued survives: no write appears
        @(posedge clk);
        #1;
        check("post-reset rf_wen",    202, 32'(rf_wen),    32'd0);
        check("post-reset lsu_count", 202, 32'(lsu_count), 32'd0);
        check("post-reset rs1_busy",  202, 32'(rs1_busy),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
